normalize_arbiter: RTL and testbench

//  Shares one pipelined vector_normalize unit among N requesters: camera ray generation, shading and reflection.

---
 rtl/normalize_arbiter_pkg.sv | 14 +
 rtl/normalize_arbiter_if.sv | 14 +
 rtl/normalize_arbiter_rr_arbiter.sv | 29 ++
 rtl/normalize_arbiter.sv | 64 ++++++
 tb/tb_normalize_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/normalize_arbiter_pkg.sv
// normalize_arbiter_pkg: shared vector and in-flight tag types for the normalize path
package vector;
  // Tag id width covers the four-requester configuration used by the tracer pipes
  localparam int IDW = 2;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vector_t;
  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } norm_tag_t;
endpackage

// File: rtl/normalize_arbiter_if.sv
// normalize_arbiter_if: requester-side request/grant/response bundle
interface normalize_arbiter_if
  import vector::*;
#(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]          req;
  vector_t [N_REQ-1:0]       op;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          rsp_valid;
  vector_t                   rsp_data;
  modport master (output req, op, input gnt, rsp_valid, rsp_data);
  modport slave  (input req, op, output gnt, rsp_valid, rsp_data);
endinterface

// File: rtl/normalize_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the search starts just past the last winner
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] r_last, w_idx, w_j;
  // Scan farthest-first so the nearest eligible requester overwrites earlier picks
  always_comb begin
    o_gnt = '0;
    w_idx = r_last;
    w_j = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = PW'((int'(r_last) + k) % N);
      if (i_req[w_j]) begin
        o_gnt = '0;
        o_gnt[w_j] = 1'b1;
        w_idx = w_j;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= PW'(N - 1);
    else if (|o_gnt) r_last <= w_idx;
endmodule

// File: rtl/normalize_arbiter.sv
// normalize_arbiter: shares one pipelined vector_normalize among requesters
// with round-robin grants, per-requester credits and a tag pipe steering results home.
module normalize_arbiter
  import vector::*;
#(
  parameter int N_REQ        = 4,
  parameter int NORM_LATENCY = 6,
  parameter int MAX_OUT      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  normalize_arbiter_if.slave bus,
  output vector_t            norm_op,
  input  vector_t            norm_result
);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [N_REQ-1:0] w_elig, w_gnt, w_rsp;
  logic [CW-1:0]    r_cnt [N_REQ];
  logic [IDW-1:0]   w_id;
  vector_t          w_op, r_norm_op;
  norm_tag_t        w_tag_in;
  norm_tag_t        r_tag [NORM_LATENCY+1];
  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_elig),
    .o_gnt (w_gnt)
  );
  always_comb begin
    w_id = '0;
    w_op = '0;
    for (int k = 0; k < N_REQ; k++)
      if (w_gnt[k]) begin
        w_id = IDW'(k);
        w_op = bus.op[k];
      end
    w_tag_in = '{valid: |w_gnt, id: w_id};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_norm_op <= '0;
      for (int k = 0; k <= NORM_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      if (|w_gnt) r_norm_op <= w_op;
      r_tag[0] <= w_tag_in;
      for (int k = 1; k <= NORM_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  assign w_rsp         = r_tag[NORM_LATENCY].valid ? N_REQ'(1) << r_tag[NORM_LATENCY].id : '0;
  assign norm_op       = r_norm_op;
  assign bus.gnt       = w_gnt;
  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_data  = norm_result;
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    // Gating with rst_n keeps gnt low while reset is held, even with req high
    assign w_elig[g] = rst_n && bus.req[g] && r_cnt[g] < CW'(MAX_OUT);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt[g] <= '0;
      else r_cnt[g] <= r_cnt[g] + CW'(w_gnt[g]) - CW'(w_rsp[g]);
    a_cnt_over: assert property (@(posedge clk) disable iff (!rst_n)
      (w_gnt[g] && !w_rsp[g]) |-> r_cnt[g] < CW'(MAX_OUT));
    a_cnt_under: assert property (@(posedge clk) disable iff (!rst_n)
      w_rsp[g] |-> r_cnt[g] != '0);
  end
endmodule

// File: tb/tb_normalize_arbiter.sv
// tb_normalize_arbiter: table vectors, corner sequences and a random run against a scoreboard model
module tb_normalize_arbiter;
  import vector::*;
  localparam int N = 4, LAT = 6, MAXO = 2;
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] rsp;
  } vec_t;
  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  vector_t norm_op, norm_result;
  vector_t npipe [LAT];
  int      n_cmp = 0, n_bad = 0, cyc = 0, m_last = N - 1;
  int      m_cnt [N];
  bit      sv [16];
  int      sp [16];
  vector_t sd [16];
  vector_t m_op = '0;
  vec_t    tbl [14];
  logic [N-1:0] t3 [10] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000,
                            4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};

  normalize_arbiter_if #(.N_REQ(N)) bus ();
  normalize_arbiter #(.N_REQ(N), .NORM_LATENCY(LAT), .MAX_OUT(MAXO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .norm_op     (norm_op),
    .norm_result (norm_result)
  );

  always #5 clk = ~clk;

  function automatic vector_t ref_norm(input vector_t v);
    vector_t r;
    r.x = v.x >>> 2;
    r.y = v.y >>> 2;
    r.z = v.z >>> 2;
    return r;
  endfunction

  function automatic vector_t rand_vec();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  // Stand-in vector_normalize: fixed LAT-cycle pipe of ref_norm
  always @(posedge clk) begin
    npipe[0] <= ref_norm(norm_op);
    for (int k = 1; k < LAT; k++) npipe[k] <= npipe[k-1];
  end
  assign norm_result = npipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_op = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    for (int i = 0; i < 16; i++) sv[i] = 1'b0;
  endtask

  task automatic step(input logic [N-1:0] rq, output logic [N-1:0] g, output logic [N-1:0] r,
                      output vector_t d, output vector_t no);
    int w, s, f;
    bus.req = rq;
    for (int i = 0; i < N; i++) bus.op[i] = rand_vec();
    @(negedge clk);
    g = bus.gnt;
    r = bus.rsp_valid;
    d = bus.rsp_data;
    no = norm_op;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      s = (m_last + k) % N;
      if (w < 0 && rq[s] && m_cnt[s] < MAXO) w = s;
    end
    s = cyc % 16;
    chk("gnt", 64'(g), w < 0 ? 64'd0 : 64'd1 << w);
    chk("rsp_valid", 64'(r), sv[s] ? 64'd1 << sp[s] : 64'd0);
    chk("norm_op", 64'(no), 64'(m_op));
    if (sv[s]) begin
      chk("rsp_data", 64'(d), 64'(sd[s]));
      m_cnt[sp[s]]--;
    end
    sv[s] = 1'b0;
    if (w >= 0) begin
      f = (cyc + LAT + 1) % 16;
      m_cnt[w]++;
      m_last = w;
      m_op = bus.op[w];
      sv[f] = 1'b1;
      sp[f] = w;
      sd[f] = ref_norm(bus.op[w]);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] g, r;
    vector_t d, no, v;
    bus.req = '0;
    for (int i = 0; i < N; i++) bus.op[i] = '0;
    for (int c = 0; c < 14; c++)
      tbl[c] = '{req: 4'b1111, gnt: 4'b0001 << (c % 4), rsp: c >= 7 ? 4'b0001 << ((c - 7) % 4) : 4'b0000};
    do_reset();

    // Single request on port 2: grant, registered operand, response 7 cycles on
    step(4'b0100, g, r, d, no);
    chk("t1_gnt", 64'(g), 64'b0100);
    v = bus.op[2];
    step(4'b0000, g, r, d, no);
    chk("t1_norm_op", 64'(no), 64'(v));
    repeat (4) step(4'b0000, g, r, d, no);
    step(4'b0000, g, r, d, no);
    chk("t1_rsp_early", 64'(r), 64'd0);
    step(4'b0000, g, r, d, no);
    chk("t1_rsp_valid", 64'(r), 64'b0100);
    chk("t1_rsp_data", 64'(d), 64'(ref_norm(v)));

    // All ports requesting: steady round-robin limited by credits
    do_reset();
    for (int c = 0; c < 14; c++) begin
      step(tbl[c].req, g, r, d, no);
      chk("t2_gnt", 64'(g), 64'(tbl[c].gnt));
      chk("t2_rsp", 64'(r), 64'(tbl[c].rsp));
    end

    // Ports 0 and 2 only: alternate, idle when both are out of credit
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(4'b0101, g, r, d, no);
      chk("t3_gnt", 64'(g), 64'(t3[c]));
    end

    // Port 1 response and grant in the same cycle leave its credit unchanged
    do_reset();
    step(4'b0010, g, r, d, no);
    repeat (6) step(4'b0000, g, r, d, no);
    step(4'b0010, g, r, d, no);
    chk("t4_rsp", 64'(r), 64'b0010);
    chk("t4_gnt_same", 64'(g), 64'b0010);
    step(4'b0010, g, r, d, no);
    chk("t4_gnt_second", 64'(g), 64'b0010);
    step(4'b0010, g, r, d, no);
    chk("t4_gnt_blocked", 64'(g), 64'b0000);

    // Reset with three ops in flight
    do_reset();
    repeat (3) step(4'b1111, g, r, d, no);
    rst_n = 1'b0;
    bus.req = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      chk("t5_rst_gnt", 64'(bus.gnt), 64'd0);
      chk("t5_rst_rsp", 64'(bus.rsp_valid), 64'd0);
      chk("t5_rst_norm_op", 64'(norm_op), 64'd0);
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      step(4'b0000, g, r, d, no);
      chk("t5_no_rsp", 64'(r), 64'd0);
    end
    step(4'b1000, g, r, d, no);
    chk("t5_first_gnt", 64'(g), 64'b1000);

    // Random traffic against the scoreboard
    do_reset();
    for (int c = 0; c < 10000; c++) step(N'($urandom_range(0, 15)), g, r, d, no);
    repeat (LAT + 2) step(4'b0000, g, r, d, no);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
